lut_gen_stream: RTL and testbench
=================================

Name: lut_gen_stream

Overview:
- Parametrised successor to the white-box LUT input generator.
- Sweeps a table address counter and emits, per address, a DATA_W-bit word of consecutive lane values (lane width 8, 16 or 32 bits).
- Adds a start/abort control FSM, valid/ready backpressure toward the LUT-build pipeline, a programmable sweep end for 32-bit mode, and a done pulse.

Parameters:
- DATA_W, 128, output word width; legal values 64, 128 or 256.
- ADDR_W, 13, address counter width; sets the maximum sweep length of 2^ADDR_W entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
- abort  in  1  synchronous cancel; highest priority after reset
- alg_mode  in  3  000 = 8-bit lanes, 001 = 16-bit lanes, 010 = 32-bit lanes, others reserved
- cfg_last  in  ADDR_W  last address for mode 010; sampled at start
- out_valid  out  1  out_addr/out_data valid
- out_ready  in  1  consumer accepts the current word
- out_addr  out  ADDR_W  current table address
- out_data  out  DATA_W  generated word
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last word is accepted
- err  out  1  one-cycle pulse when start is given with a reserved mode

Behaviour:
- Reset: state IDLE; cnt, mode_q and last_q are 0; out_valid, busy, done and err are 0.
- out_addr equals cnt at all times; out_data is 0 in IDLE and DONE.
- Lane width LW = 8, 16 or 32 from mode_q. Lane count L = DATA_W/LW.
- Lane k (k = 0 is the most significant lane) carries (cnt*L + k) truncated or zero-extended to LW bits.
- Example: DATA_W=128, mode 000, cnt=1 gives out_data = 0x101112...1F.
- last_q is latched at start:
  - modes 000 and 001: min(2^LW/L, 2^ADDR_W) - 1. At the defaults this is 15 for mode 000 and 8191 for mode 001.
  - mode 010: cfg_last.
- mode_q and last_q are frozen for the whole sweep; alg_mode and cfg_last changes during RUN are ignored.
- FSM is IDLE, RUN, DONE.
- IDLE:
  - start with a legal mode → RUN on the next cycle; cnt = 0; mode_q and last_q loaded.
  - start with a reserved mode → err = 1 for one cycle; stay in IDLE.
- RUN:
  - out_valid = 1 and busy = 1.
  - A transfer occurs when out_valid and out_ready are both 1.
  - Transfer with cnt != last_q → cnt increments next cycle.
  - Transfer with cnt == last_q → DONE next cycle; cnt returns to 0.
  - out_ready low → cnt, out_addr and out_data hold stable; no value is skipped or repeated.
- DONE: done = 1 for exactly one cycle, then IDLE. A start in this cycle is ignored.
- abort has priority over start and over transfers:
  - any state → IDLE next cycle, cnt = 0, out_valid = 0, no done pulse.
  - abort together with the final transfer: the final word counts as accepted downstream, but done is not asserted.
- start while busy is ignored.
- Single-entry sweep (mode 010, cfg_last = 0): exactly one word, then done.
- Reset asserted mid-sweep clears everything immediately and asynchronously; no done pulse.
- Counter arithmetic is ADDR_W bits wide.
- Lane arithmetic uses ADDR_W + log2(L) bits before truncation to LW, so 8-bit lanes wrap modulo 256 as intended.
- Throughput: one word per cycle while out_ready is held high.
- Latency: the first word is valid one cycle after start.

Test Plan:
- Mode 000, DATA_W=128, out_ready = 1, pulse start → 16 words:
  - addr 0..15;
  - word 0 = 0x000102...0F, word 15 = 0xF0F1...FF;
  - done pulses once, one cycle after addr 15 is accepted;
  - busy is high for exactly 16 cycles.
- Mode 001, out_ready = 1 → 8192 words:
  - addr 8191 carries 0xFFF8FFF9...FFFF;
  - the cycle after the addr 8191 transfer is DONE with done = 1; the cycle after that is IDLE.
- Mode 010 with cfg_last = 3, out_ready toggled pseudo-randomly → exactly 4 accepted words:
  - lanes 0x00000000..0x0000000F in order;
  - data is stable while out_ready = 0;
  - changing cfg_last and alg_mode mid-sweep has no effect.
- Mode 000, abort asserted at addr 7 → IDLE next cycle, out_valid = 0, no done pulse. A following start restarts from addr 0.
- Start with alg_mode = 101 → err pulses once, busy stays 0. Start while busy is ignored (addr sequence unchanged).
- rst_n low at addr 5 of a mode 001 sweep → all outputs 0 immediately; after release the block idles until the next start.

Source files
------------

// File: rtl/lut_gen_stream.sv
`timescale 1ns/1ps
// Sweeps a table address and emits one word of consecutive lane values per address.
// First word valid one cycle after start; counter and data hold while out_ready is low.
module lut_gen_stream #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        alg_mode,
    input  logic [ADDR_W-1:0] cfg_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int L8  = DATA_W / 8;
    localparam int L16 = DATA_W / 16;
    localparam int L32 = DATA_W / 32;
    localparam int S8  = $clog2(L8);
    localparam int S16 = $clog2(L16);
    localparam int S32 = $clog2(L32);
    localparam int TW  = ADDR_W + 32;

    // Natural sweep end: stop once lane values would wrap, or at the counter limit.
    localparam logic [63:0] CAP    = 64'd1 << ADDR_W;
    localparam logic [63:0] E8     = 64'd256 / 64'(L8);
    localparam logic [63:0] E16    = 64'd65536 / 64'(L16);
    localparam logic [63:0] LAST8  = ((E8 < CAP) ? E8 : CAP) - 64'd1;
    localparam logic [63:0] LAST16 = ((E16 < CAP) ? E16 : CAP) - 64'd1;
    localparam logic [ADDR_W-1:0] LAST8_A  = LAST8[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST16_A = LAST16[ADDR_W-1:0];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [1:0]        mode_q, mode_d;
    logic              err_q, err_d;
    logic              legal;
    logic [DATA_W-1:0] d8, d16, d32;

    assign legal = (alg_mode == 3'b000) || (alg_mode == 3'b001) || (alg_mode == 3'b010);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        mode_d  = alg_mode[1:0];
                        if (alg_mode == 3'b010)
                            last_d = cfg_last;
                        else if (alg_mode == 3'b000)
                            last_d = LAST8_A;
                        else
                            last_d = LAST16_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (cnt_q == last_q) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    // Lane k holds cnt*L + k; L is a power of two so this is {cnt, k} truncated to the lane.
    always_comb begin
        d8  = '0;
        d16 = '0;
        d32 = '0;
        for (int k = 0; k < L8; k++)
            d8[DATA_W-1-8*k -: 8] = 8'((TW'(cnt_q) << S8) | TW'(k));
        for (int k = 0; k < L16; k++)
            d16[DATA_W-1-16*k -: 16] = 16'((TW'(cnt_q) << S16) | TW'(k));
        for (int k = 0; k < L32; k++)
            d32[DATA_W-1-32*k -: 32] = 32'((TW'(cnt_q) << S32) | TW'(k));
    end

    always_comb begin
        out_data = '0;
        if (state_q == S_RUN) begin
            case (mode_q)
                2'b00:   out_data = d8;
                2'b01:   out_data = d16;
                default: out_data = d32;
            endcase
        end
    end

    assign out_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign out_addr  = cnt_q;

endmodule

// File: tb/tb_lut_gen_stream.sv
`timescale 1ns/1ps
// Directed sequence of sweeps, aborts, resets and error starts checked against a lane-arithmetic model.
module tb_lut_gen_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   alg_mode = 3'd0;
    logic [12:0]  cfg_last = 13'd0;
    logic         out_ready = 1'b0;
    logic         out_valid, busy, done, err;
    logic [12:0]  out_addr;
    logic [127:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_gen_stream #(.DATA_W(128), .ADDR_W(13)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .alg_mode  (alg_mode),
        .cfg_last  (cfg_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word n of a sweep: lane k (MSB first) = (n*L + k) mod 2^LW.
    function automatic logic [127:0] model(input int mode, input int n);
        int lw, l;
        logic [127:0] w;
        longint v;
        lw = 8 << mode;
        l  = 128 / lw;
        w  = '0;
        for (int k = 0; k < l; k++) begin
            v = (longint'(n) * l + k) % (longint'(1) << lw);
            w = (w << lw) | 128'(v);
        end
        return w;
    endfunction

    task automatic sweep(input logic [2:0] mode, input logic [12:0] lst, input int nwords,
                         input bit rnd, input bit mess,
                         output logic [127:0] first_d, output logic [127:0] last_d);
        int n, busy_n, last_x;
        bit hold, got_done;
        logic [12:0]  h_a;
        logic [127:0] h_d;
        n = 0; busy_n = 0; last_x = -10; hold = 0; got_done = 0;
        h_a = '0; h_d = '0; first_d = '0; last_d = '0;
        alg_mode = mode; cfg_last = lst; out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < nwords * 8 + 50 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1;
                chk("done_one_after_last", 128'(cyc - last_x), 128'd1);
                chk("done_addr", 128'(out_addr), 128'd0);
                chk("done_data", out_data, 128'd0);
                chk("done_valid", 128'(out_valid), 128'd0);
                alg_mode = mode;
                start = 1'b1;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mess) begin
                    alg_mode = 3'($urandom);
                    cfg_last = 13'($urandom);
                    start    = 1'($urandom_range(0, 1));
                end
                if (busy) busy_n++;
                if (hold) begin
                    chk("hold_addr", 128'(out_addr), 128'(h_a));
                    chk("hold_data", out_data, h_d);
                end
                hold = 0;
                if (out_valid && out_ready) begin
                    chk("addr", 128'(out_addr), 128'(n));
                    chk("data", out_data, model(int'(mode), n));
                    if (n == 0) first_d = out_data;
                    last_d = out_data;
                    n++;
                    last_x = cyc;
                end else if (out_valid) begin
                    hold = 1; h_a = out_addr; h_d = out_data;
                end
                tick();
            end
        end
        chk("done_seen", 128'(got_done), 128'd1);
        chk("word_count", 128'(n), 128'(nwords));
        if (!rnd) chk("busy_cycles", 128'(busy_n), 128'(nwords));
        tick();
        start = 1'b0;
        chk("post_done_busy", 128'(busy), 128'd0);
        chk("post_done_done", 128'(done), 128'd0);
        chk("post_done_valid", 128'(out_valid), 128'd0);
        tick();
        chk("start_in_done_ignored", 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] f, l;
        #12;
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_addr", 128'(out_addr), 128'd0);
        chk("rst_data", out_data, 128'd0);
        rst_n = 1'b1;
        tick();

        sweep(3'b000, 13'd0, 16, 0, 0, f, l);
        chk("m0_first", f, 128'h000102030405060708090A0B0C0D0E0F);
        chk("m0_last", l, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        sweep(3'b001, 13'd0, 8192, 0, 0, f, l);
        chk("m1_last", l, 128'hFFF8FFF9FFFAFFFBFFFCFFFDFFFEFFFF);

        sweep(3'b010, 13'd3, 4, 1, 1, f, l);
        chk("m2_first", f, 128'h00000000000000010000000200000003);
        chk("m2_last", l, 128'h0000000C0000000D0000000E0000000F);

        // Abort mid-sweep, then a clean restart.
        alg_mode = 3'b000; out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && out_addr != 13'd7; i++) tick();
        chk("abort_at_addr", 128'(out_addr), 128'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 128'(out_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_addr", 128'(out_addr), 128'd0);
        chk("abort_data", out_data, 128'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 128'(done), 128'd0);
            tick();
        end
        sweep(3'b000, 13'd0, 16, 0, 0, f, l);
        chk("restart_first", f, 128'h000102030405060708090A0B0C0D0E0F);

        // Reserved mode.
        alg_mode = 3'b101; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 128'(err), 128'd1);
        chk("err_busy", 128'(busy), 128'd0);
        tick();
        chk("err_once", 128'(err), 128'd0);
        chk("err_busy_after", 128'(busy), 128'd0);

        // Asynchronous reset mid-sweep.
        alg_mode = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && out_addr != 13'd5; i++) tick();
        chk("rst_at_addr", 128'(out_addr), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_done", 128'(done), 128'd0);
        chk("arst_addr", 128'(out_addr), 128'd0);
        chk("arst_data", out_data, 128'd0);
        #10;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", 128'(busy), 128'd0);
        chk("post_rst_valid", 128'(out_valid), 128'd0);
        chk("post_rst_done", 128'(done), 128'd0);

        sweep(3'b010, 13'd0, 1, 0, 0, f, l);
        chk("single_word", f, 128'h00000000000000010000000200000003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
